// File: rtl/shift_sched_pkg.sv
// Shared encodings and widths for the shifter scheduler and its decoder.
package shift_sched_pkg;

    localparam int XLEN   = 32;
    localparam int SHAMTW = 5;

    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b01,
        SH_SRA = 2'b10,
        SH_RSV = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_sched_shamt_decode.sv
// 5-to-32 one-hot shift-select decoder plus the sign-fill mask used for SRA.
module shift_sched_shamt_decode
    import shift_sched_pkg::*;
(
    input  logic [SHAMTW-1:0] shamt,
    output logic [XLEN-1:0]   sel,
    output logic [XLEN-1:0]   fill
);

    generate
        for (genvar gi = 0; gi < XLEN; gi++) begin : g_sel
            assign sel[gi] = (shamt == SHAMTW'(gi));
        end
    endgenerate

    // Top shamt bits set; a zero shift needs no fill at all.
    assign fill = (shamt == '0) ? '0 : ~({XLEN{1'b1}} >> shamt);

endmodule

// File: rtl/shift_sched.sv
// Two-requester round-robin scheduler driving a shared one-hot-select shifter.
module shift_sched #(
    parameter int TAGW = 4,
    parameter int XLEN = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [1:0]                req_valid,
    output logic [1:0]                req_ready,
    input  logic [1:0][1:0]           req_op,
    input  logic [1:0][4:0]           req_shamt,
    input  logic [1:0][XLEN-1:0]      req_data,
    input  logic [1:0][TAGW-1:0]      req_tag,
    output logic [XLEN-1:0]           sh_sel,
    output logic [XLEN-1:0]           sh_din,
    input  logic [XLEN-1:0]           sh_left,
    input  logic [XLEN-1:0]           sh_right,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [XLEN-1:0]           rsp_data,
    output logic                      rsp_id,
    output logic [TAGW-1:0]           rsp_tag,
    output logic                      rsp_err
);
    import shift_sched_pkg::*;

    state_t          state_reg, state_next;
    logic            rr_ptr_reg;
    logic [1:0]      grant;
    logic            accept;
    logic            acc_id;
    op_t             op_reg;
    logic [XLEN-1:0] sel_reg, din_reg, fill_reg;
    logic [XLEN-1:0] dec_sel, dec_fill;
    logic [TAGW-1:0] tag_reg;
    logic            id_reg;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] rsp_data_reg;
    logic            rsp_err_reg;

    // Preferred requester wins when both are valid.
    always_comb begin
        grant = 2'b00;
        if (req_valid[rr_ptr_reg]) begin
            grant[rr_ptr_reg] = 1'b1;
        end else if (req_valid[~rr_ptr_reg]) begin
            grant[~rr_ptr_reg] = 1'b1;
        end
    end

    assign accept = |req_ready;
    assign acc_id = req_ready[1];

    shift_sched_shamt_decode u_decode (
        .shamt (req_shamt[acc_id]),
        .sel   (dec_sel),
        .fill  (dec_fill)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (accept) state_next = ST_SHIFT;
            ST_SHIFT: state_next = ST_RESP;
            ST_RESP:  if (rsp_ready) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = 2'b00;
        rsp_valid = 1'b0;
        case (state_reg)
            ST_IDLE: req_ready = grant;
            ST_RESP: rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // The shifter itself is logical-only; SRA ORs in the precomputed sign fill.
    always_comb begin
        case (op_reg)
            SH_SLL:  result = sh_left;
            SH_SRL:  result = sh_right;
            SH_SRA:  result = sh_right | (din_reg[XLEN-1] ? fill_reg : '0);
            default: result = '0;
        endcase
    end

    // Select and operand are loaded at accept so they are stable for all of SHIFT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_reg   <= 1'b0;
            op_reg       <= SH_SLL;
            sel_reg      <= {{(XLEN-1){1'b0}}, 1'b1};
            din_reg      <= '0;
            fill_reg     <= '0;
            tag_reg      <= '0;
            id_reg       <= 1'b0;
            rsp_data_reg <= '0;
            rsp_err_reg  <= 1'b0;
        end else begin
            if (accept) begin
                rr_ptr_reg <= ~acc_id;
                op_reg     <= op_t'(req_op[acc_id]);
                sel_reg    <= dec_sel;
                fill_reg   <= dec_fill;
                din_reg    <= req_data[acc_id];
                tag_reg    <= req_tag[acc_id];
                id_reg     <= acc_id;
            end
            if (state_reg == ST_SHIFT) begin
                rsp_data_reg <= result;
                rsp_err_reg  <= (op_reg == SH_RSV);
            end
        end
    end

    assign sh_sel   = sel_reg;
    assign sh_din   = din_reg;
    assign rsp_data = rsp_data_reg;
    assign rsp_err  = rsp_err_reg;
    assign rsp_id   = id_reg;
    assign rsp_tag  = tag_reg;

endmodule

// File: tb/tb_shift_sched.sv
// Bench for shift_sched: directed cases plus random traffic against a transaction-level model.
module tb_shift_sched;

    localparam int TAGW = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [1:0]           req_valid;
    logic [1:0]           req_ready;
    logic [1:0][1:0]      req_op;
    logic [1:0][4:0]      req_shamt;
    logic [1:0][31:0]     req_data;
    logic [1:0][TAGW-1:0] req_tag;
    logic [31:0]          sh_sel, sh_din, sh_left, sh_right;
    logic                 rsp_valid, rsp_ready;
    logic [31:0]          rsp_data;
    logic                 rsp_id;
    logic [TAGW-1:0]      rsp_tag;
    logic                 rsp_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    shift_sched #(.TAGW(TAGW), .XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_shamt (req_shamt),
        .req_data  (req_data),
        .req_tag   (req_tag),
        .sh_sel    (sh_sel),
        .sh_din    (sh_din),
        .sh_left   (sh_left),
        .sh_right  (sh_right),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_tag   (rsp_tag),
        .rsp_err   (rsp_err)
    );

    // Behavioural shared shifter: amount is the position of the select bit.
    int sh_k;
    always_comb begin
        sh_k = 0;
        for (int b = 31; b >= 0; b--) begin
            if (sh_sel[b]) sh_k = b;
        end
        sh_left  = sh_din << sh_k;
        sh_right = sh_din >> sh_k;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [4:0] sh,
                                               input logic [31:0] d);
        logic signed [31:0] s;
        s = d;
        case (op)
            2'b00:   return d << sh;
            2'b01:   return d >> sh;
            2'b10:   return 32'(s >>> sh);
            default: return 32'h0;
        endcase
    endfunction

    // Transaction model: busy from accept until response handshake; response due two cycles after accept.
    bit              armed = 0, busy = 0, pref = 0, just_reset = 0;
    int              age = 0;
    int              n_rsp = 0;
    logic            e_id;
    logic [1:0]      e_op;
    logic [4:0]      e_sh;
    logic [31:0]     e_data;
    logic [TAGW-1:0] e_tag;

    always @(negedge clk) begin
        logic [1:0] exp_ready;
        logic       win;
        exp_ready = 2'b00;
        if (armed) begin
            if (!busy) begin
                if (req_valid[pref]) exp_ready[pref] = 1'b1;
                else if (req_valid[!pref]) exp_ready[!pref] = 1'b1;
            end
            chk("req_ready", 32'(req_ready), 32'(exp_ready));
            chk("rsp_valid", 32'(rsp_valid), 32'(busy && age >= 2));
            chk("sel_onehot", 32'($onehot(sh_sel)), 32'd1);
            if (busy && age == 1) begin
                chk("shift_sel", sh_sel, 32'd1 << e_sh);
                chk("shift_din", sh_din, e_data);
            end
            if (busy && age >= 2) begin
                chk("rsp_data", rsp_data, ref_result(e_op, e_sh, e_data));
                chk("rsp_id", 32'(rsp_id), 32'(e_id));
                chk("rsp_tag", 32'(rsp_tag), 32'(e_tag));
                chk("rsp_err", 32'(rsp_err), 32'(e_op == 2'b11));
            end
            if (just_reset) begin
                chk("rst_data", rsp_data, 32'h0);
                chk("rst_id", 32'(rsp_id), 32'h0);
                chk("rst_tag", 32'(rsp_tag), 32'h0);
                chk("rst_err", 32'(rsp_err), 32'h0);
                chk("rst_sel", sh_sel, 32'h1);
                chk("rst_din", sh_din, 32'h0);
            end
        end
        just_reset = 0;
        if (rst_n !== 1'b1) begin
            armed      = 1;
            busy       = 0;
            pref       = 0;
            just_reset = 1;
        end else if (armed) begin
            if (!busy) begin
                if (exp_ready != 2'b00) begin
                    win    = exp_ready[1];
                    busy   = 1;
                    age    = 1;
                    e_id   = win;
                    e_op   = req_op[win];
                    e_sh   = req_shamt[win];
                    e_data = req_data[win];
                    e_tag  = req_tag[win];
                    pref   = !win;
                end
            end else if (age >= 2) begin
                if (rsp_ready) begin
                    busy = 0;
                    n_rsp++;
                    $display("rsp #%0d id=%0d tag=%0h op=%0d shamt=%0d din=%08h data=%08h err=%0d",
                             n_rsp, rsp_id, rsp_tag, e_op, e_sh, e_data, rsp_data, rsp_err);
                end
            end else begin
                age++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [1:0] op, input logic [4:0] sh,
                           input logic [31:0] d, input logic [TAGW-1:0] tag);
        req_op[i]    = op;
        req_shamt[i] = sh;
        req_data[i]  = d;
        req_tag[i]   = tag;
    endtask

    // Raises valid, waits (bounded) for the accept, then drops valid; returns one cycle after accept.
    task automatic issue(input int i, input logic [1:0] op, input logic [4:0] sh,
                         input logic [31:0] d, input logic [TAGW-1:0] tag);
        bit done;
        done = 0;
        set_req(i, op, sh, d, tag);
        req_valid[i] = 1'b1;
        for (int n = 0; n < 50 && !done; n++) begin
            #1;
            if (req_ready[i]) done = 1;
            @(posedge clk);
            #1;
        end
        req_valid[i] = 1'b0;
        if (!done) chk("issue_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        bit [1:0] pend;
        bit [1:0] acc;
        rst_n     = 1'b0;
        req_valid = 2'b00;
        req_op    = '0;
        req_shamt = '0;
        req_data  = '0;
        req_tag   = '0;
        rsp_ready = 1'b1;
        repeat (3) step();
        rst_n = 1'b1;

        issue(0, 2'b00, 5'd4, 32'h0000_0001, 4'd3);
        issue(0, 2'b01, 5'd4, 32'h8000_0000, 4'd1);
        issue(0, 2'b10, 5'd4, 32'h8000_0000, 4'd2);
        issue(0, 2'b10, 5'd31, 32'h8000_0000, 4'd4);
        issue(0, 2'b10, 5'd0, 32'h8000_0000, 4'd5);
        issue(1, 2'b11, 5'd7, 32'hDEAD_BEEF, 4'd9);
        issue(1, 2'b00, 5'd1, 32'h0000_0005, 4'hA);
        repeat (4) step();

        // Both requesters valid from reset: grants must alternate starting with 0.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        set_req(0, 2'b00, 5'd2, 32'h0000_0003, 4'h1);
        set_req(1, 2'b10, 5'd8, 32'hF000_0000, 4'h2);
        req_valid = 2'b11;
        repeat (14) step();
        req_valid = 2'b00;
        repeat (4) step();

        // Response backpressure with requester 1 waiting.
        issue(0, 2'b00, 5'd8, 32'h0000_00AB, 4'h6);
        set_req(1, 2'b01, 5'd3, 32'h0000_0F00, 4'h7);
        req_valid[1] = 1'b1;
        rsp_ready    = 1'b0;
        repeat (7) step();
        rsp_ready = 1'b1;
        issue(1, 2'b01, 5'd3, 32'h0000_0F00, 4'h7);
        repeat (4) step();

        // Reset while in SHIFT, then both valid: requester 0 must be served.
        issue(1, 2'b00, 5'd3, 32'h0000_0011, 4'hC);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        set_req(0, 2'b01, 5'd1, 32'h0000_0040, 4'hD);
        set_req(1, 2'b00, 5'd1, 32'h0000_0040, 4'hE);
        req_valid = 2'b11;
        step();
        req_valid = 2'b00;
        repeat (5) step();

        // Random traffic with withdrawals, backpressure and occasional reset.
        pend = 2'b00;
        for (int c = 0; c < 600; c++) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst_n     = ($urandom_range(0, 99) != 0);
            for (int i = 0; i < 2; i++) begin
                if (!pend[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        pend[i] = 1'b1;
                        set_req(i, 2'($urandom_range(0, 3)), 5'($urandom), $urandom, 4'($urandom));
                    end
                end else if ($urandom_range(0, 19) == 0) begin
                    pend[i] = 1'b0;
                end
            end
            req_valid = pend;
            #1;
            acc = req_valid & req_ready;
            @(posedge clk);
            #1;
            pend = pend & ~acc;
        end
        rst_n     = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        repeat (6) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
